// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding, NOP encoding, default reset PC.
// Build option: MISALIGN_CHK_EN adds the HALT state used by the misaligned-target trap.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef MISALIGN_CHK_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3
  } fetch_state_t;
`endif

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: sequential pc+4 (wrapping) or word-aligned branch target.
// Build option: MISALIGN_CHK_EN exposes a flag for taken branches to non-word-aligned targets.
module next_pc_sel
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target
`ifdef MISALIGN_CHK_EN
  ,
  output logic        misaligned
`endif
);

  logic [31:0] next_pc_int;

  // Select the redirect target with its low bits cleared, otherwise step to the next word.
  always_comb begin
    next_pc_int = pc + 32'd4;
    if (br_taken) begin
      next_pc_int = br_target & ~32'h0000_0003;
    end
  end

`ifdef MISALIGN_CHK_EN
  // A taken branch whose target is not word aligned is flagged to the fetch FSM.
  always_comb begin
    misaligned = br_taken && (br_target[1:0] != 2'b00);
  end
`endif

  // Exported result of the selection.
  logic [31:0] next_pc;
  assign next_pc = next_pc_int;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one word request per instruction, holds the
// response until the consumer accepts it, then steps or redirects the PC.
// Build option: MISALIGN_CHK_EN adds the sticky misalign_o flag and HALT state.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
`ifdef MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  instr_q;
  logic [31:0]  next_pc;
  logic         accept;

  assign accept = (state == HOLD) && instr_ready_i;

`ifdef MISALIGN_CHK_EN
  logic misaligned;
  logic misalign_q;

  next_pc_sel u_next_pc_sel (
    .pc         (pc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .misaligned (misaligned)
  );
`else
  next_pc_sel u_next_pc_sel (
    .pc        (pc),
    .br_taken  (br_taken),
    .br_target (br_target)
  );
`endif

  assign next_pc = u_next_pc_sel.next_pc;

  // State register; reset parks the FSM in IDLE for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and request/valid outputs; grant and response only count in their own state.
  always_comb begin
    state_next    = state;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) state_next = HOLD;
      end
      HOLD: begin
        instr_valid_o = 1'b1;
        if (instr_ready_i) begin
`ifdef MISALIGN_CHK_EN
          state_next = misaligned ? HALT : REQ;
`else
          state_next = REQ;
`endif
        end
      end
`ifdef MISALIGN_CHK_EN
      HALT: state_next = HALT;
`endif
      default: state_next = IDLE;
    endcase
  end

  // PC advances only when the held instruction is accepted (and not trapped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
`ifdef MISALIGN_CHK_EN
    end else if (accept && !misaligned) begin
`else
    end else if (accept) begin
`endif
      pc <= next_pc;
    end
  end

  // Capture the read data only while a response is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
    end else if ((state == WAIT) && imem_rvalid_i) begin
      instr_q <= imem_rdata_i;
    end
  end

`ifdef MISALIGN_CHK_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (accept && misaligned) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign instr_o     = instr_q;

endmodule
